// File: rtl/maze_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : maze_sram_responder
// Summary  : Single-port SRAM with a registered read port. Defining
//            MAZE_SRAM_SCAN_EN adds a D-triggered checksum / non-zero scan.
// Revision : 1.0  initial release
// ============================================================================
module maze_sram_responder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  D,
  output logic                  busy,
  output logic                  scan_done,
  output logic [15:0]           checksum,
  output logic [ADDR_WIDTH:0]   nz_count
);

  localparam int c_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  w_access_en;

  // Storage is never reset so it can map onto a plain RAM macro.
  always_ff @(posedge clk) begin
    if (reset && cs && we && w_access_en) begin
      r_mem[address] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_out <= '0;
    end else if (cs && !we && w_access_en) begin
      r_data_out <= r_mem[address];
    end
  end

  assign data_out = r_data_out;

`ifdef MAZE_SRAM_SCAN_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_d_q;
  logic [ADDR_WIDTH-1:0] r_scan_addr;
  logic [15:0]           r_checksum;
  logic [ADDR_WIDTH:0]   r_nz_count;
  logic                  r_busy;
  logic                  r_scan_done;
  logic [DATA_WIDTH-1:0] w_scan_word;

  assign w_scan_word = r_mem[r_scan_addr];
  // The router is locked out of the array for the whole sweep.
  assign w_access_en = (r_state != SCAN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_d_q       <= 1'b0;
      r_scan_addr <= '0;
      r_checksum  <= '0;
      r_nz_count  <= '0;
      r_busy      <= 1'b0;
      r_scan_done <= 1'b0;
    end else begin
      r_d_q <= D;
      case (r_state)
        IDLE: begin
          if (D && !r_d_q) begin
            r_state     <= SCAN;
            r_busy      <= 1'b1;
            r_scan_addr <= '0;
            r_checksum  <= '0;
            r_nz_count  <= '0;
          end
        end
        SCAN: begin
          r_checksum  <= r_checksum + 16'(w_scan_word);
          r_scan_addr <= r_scan_addr + ADDR_WIDTH'(1);
          if (w_scan_word != '0) begin
            r_nz_count <= r_nz_count + (ADDR_WIDTH+1)'(1);
          end
          if (r_scan_addr == '1) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_scan_done <= 1'b1;
          end
        end
        DONE: begin
          if (!D) begin
            r_state     <= IDLE;
            r_scan_done <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_scan_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign scan_done = r_scan_done;
  assign checksum  = r_checksum;
  assign nz_count  = r_nz_count;
`else
  logic w_unused_d;

  assign w_unused_d  = D;
  assign w_access_en = 1'b1;
  assign busy        = 1'b0;
  assign scan_done   = 1'b0;
  assign checksum    = '0;
  assign nz_count    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_maze_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_maze_sram_responder
// Summary  : Randomised self-checking bench against an array reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_maze_sram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  address = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic        D = 1'b0;
  logic        busy;
  logic        scan_done;
  logic [15:0] checksum;
  logic [8:0]  nz_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_mem [256];
  logic [7:0] m_dout = '0;

  maze_sram_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .data_out(data_out), .cs(cs), .we(we), .D(D), .busy(busy),
    .scan_done(scan_done), .checksum(checksum), .nz_count(nz_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One router cycle; the model only changes when the access is not locked out.
  task automatic access(input bit c, input bit w, input logic [7:0] a,
                        input logic [7:0] d, input bit blocked);
    cs = c; we = w; address = a; data_in = d;
    tick();
    if (c && !blocked) begin
      if (w) m_mem[a] = d;
      else   m_dout = m_mem[a];
    end
    cs = 1'b0; we = 1'b0;
  endtask

  function automatic logic [15:0] model_sum();
    int s = 0;
    for (int i = 0; i < 256; i++) s += int'(m_mem[i]);
    return s[15:0];
  endfunction

  function automatic logic [8:0] model_nz();
    int n = 0;
    for (int i = 0; i < 256; i++) if (m_mem[i] != 8'h00) n++;
    return n[8:0];
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", data_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (scan_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", scan_done); end
    n_vec++; if (checksum !== 16'h0000) begin n_err++; $display("FAIL reset_sum: got %h want 0000", checksum); end
    n_vec++; if (nz_count !== 9'h000) begin n_err++; $display("FAIL reset_nz: got %h want 000", nz_count); end
    reset = 1'b1;
    m_dout = 8'h00;
    tick();
  endtask

  task automatic test_write_read();
    access(1, 1, 8'h10, 8'hA5, 0);
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL wr_hold: got %h want 00", data_out); end
    cs = 1'b1; we = 1'b0; address = 8'h10;
    @(negedge clk);
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL pre_read_hold: got %h want 00", data_out); end
    tick();
    m_dout = m_mem[8'h10];
    cs = 1'b0;
    n_vec++; if (data_out !== 8'hA5) begin n_err++; $display("FAIL read_a5: got %h want a5", data_out); end
  endtask

  task automatic test_raw();
    access(1, 1, 8'h22, 8'h3C, 0);
    access(1, 0, 8'h22, 8'h00, 0);
    n_vec++; if (data_out !== 8'h3C) begin n_err++; $display("FAIL raw: got %h want 3c", data_out); end
    for (int k = 0; k < 4; k++) begin
      access(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 0);
      n_vec++; if (data_out !== 8'h3C) begin n_err++; $display("FAIL cs0_hold: got %h want 3c", data_out); end
    end
  endtask

  task automatic test_random_access();
    for (int i = 0; i < 256; i++)
      access(1, 1, 8'(i), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), 0);
    for (int k = 0; k < 300; k++) begin
      access(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 0);
      n_vec++; if (data_out !== m_dout) begin n_err++; $display("FAIL rand_access: got %h want %h", data_out, m_dout); end
    end
  endtask

`ifdef MAZE_SRAM_SCAN_EN
  task automatic test_scan_ramp();
    int cnt = 0;
    for (int i = 0; i < 256; i++) access(1, 1, 8'(i), 8'(i), 0);
    D = 1'b1;
    tick();
    for (int k = 0; k < 400 && !scan_done; k++) begin
      if (busy) cnt++;
      if (k == 20) D = 1'b0;
      tick();
    end
    n_vec++; if (cnt != 256) begin n_err++; $display("FAIL busy_cycles: got %0d want 256", cnt); end
    n_vec++; if (scan_done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL done_flags: got done=%b busy=%b want done=1 busy=0", scan_done, busy); end
    n_vec++; if (checksum !== 16'h7F80 || checksum !== model_sum()) begin n_err++; $display("FAIL ramp_sum: got %h want 7f80", checksum); end
    n_vec++; if (nz_count !== 9'd255) begin n_err++; $display("FAIL ramp_nz: got %0d want 255", nz_count); end
    tick();
    n_vec++; if (scan_done !== 1'b0 || checksum !== 16'h7F80) begin n_err++; $display("FAIL idle_hold: got done=%b sum=%h want done=0 sum=7f80", scan_done, checksum); end
  endtask

  task automatic test_scan_block();
    logic [7:0] held;
    int waited = 0;
    D = 1'b1;
    tick();
    held = m_dout;
    access(1, 1, 8'h05, 8'hFF, 1);
    access(1, 0, 8'h05, 8'h00, 1);
    n_vec++; if (data_out !== held) begin n_err++; $display("FAIL scan_read_ignored: got %h want %h", data_out, held); end
    while (!scan_done && waited < 400) begin tick(); waited++; end
    n_vec++; if (scan_done !== 1'b1) begin n_err++; $display("FAIL scan_timeout: got done=%b want 1", scan_done); end
    for (int k = 0; k < 3; k++) begin
      access(1, 0, 8'h05, 8'h00, 0);
      n_vec++; if (scan_done !== 1'b1) begin n_err++; $display("FAIL done_stays: got %b want 1", scan_done); end
    end
    n_vec++; if (data_out !== 8'h05) begin n_err++; $display("FAIL blocked_write: got %h want 05", data_out); end
    n_vec++; if (checksum !== 16'h7F80) begin n_err++; $display("FAIL block_sum: got %h want 7f80", checksum); end
    D = 1'b0;
    tick();
    n_vec++; if (scan_done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL back_idle: got done=%b busy=%b want 0 0", scan_done, busy); end
  endtask

  task automatic test_scan_reset();
    D = 1'b1;
    tick();
    repeat (100) tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_mid: got %b want 1", busy); end
    #2 reset = 1'b0;
    #1;
    m_dout = 8'h00;
    n_vec++; if (busy !== 1'b0 || scan_done !== 1'b0) begin n_err++; $display("FAIL async_flags: got busy=%b done=%b want 0 0", busy, scan_done); end
    n_vec++; if (checksum !== 16'h0000 || nz_count !== 9'h000) begin n_err++; $display("FAIL async_sum: got %h/%h want 0000/000", checksum, nz_count); end
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL async_dout: got %h want 00", data_out); end
    D = 1'b0;
    tick();
    reset = 1'b1;
    access(1, 0, 8'h80, 8'h00, 0);
    n_vec++; if (data_out !== 8'h80 || data_out !== m_dout) begin n_err++; $display("FAIL post_reset_read: got %h want 80", data_out); end
  endtask

  task automatic test_scan_random();
    int waited = 0;
    logic [7:0] held;
    for (int i = 0; i < 256; i++)
      access(1, 1, 8'(i), ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom), 0);
    access(1, 0, 8'($urandom), 8'h00, 0);
    held = m_dout;
    D = 1'b1;
    tick();
    D = 1'b0;
    for (int k = 0; k < 50; k++)
      access(1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1);
    n_vec++; if (data_out !== held) begin n_err++; $display("FAIL rand_scan_dout: got %h want %h", data_out, held); end
    while (!scan_done && waited < 400) begin tick(); waited++; end
    n_vec++; if (checksum !== model_sum()) begin n_err++; $display("FAIL rand_sum: got %h want %h", checksum, model_sum()); end
    n_vec++; if (nz_count !== model_nz()) begin n_err++; $display("FAIL rand_nz: got %0d want %0d", nz_count, model_nz()); end
    tick();
  endtask
`else
  task automatic test_no_scan();
    D = 1'b1;
    for (int k = 0; k < 6; k++) begin
      access(1, 1'(k % 2), 8'(k / 2 + 8'h40), 8'($urandom), 0);
      n_vec++; if (data_out !== m_dout) begin n_err++; $display("FAIL pulse_access: got %h want %h", data_out, m_dout); end
      n_vec++; if (busy !== 1'b0 || scan_done !== 1'b0 || checksum !== 16'h0 || nz_count !== 9'h0) begin
        n_err++; $display("FAIL no_scan_outputs: got busy=%b done=%b sum=%h nz=%h want 0", busy, scan_done, checksum, nz_count);
      end
    end
    D = 1'b0;
    repeat (3) tick();
    n_vec++; if (busy !== 1'b0 || scan_done !== 1'b0 || checksum !== 16'h0) begin n_err++; $display("FAIL no_scan_after: got busy=%b done=%b sum=%h want 0", busy, scan_done, checksum); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_raw();
    test_random_access();
`ifdef MAZE_SRAM_SCAN_EN
    test_scan_ramp();
    test_scan_block();
    test_scan_reset();
    test_scan_random();
`else
    test_no_scan();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
